// File: rtl/othello_pkg.sv
// Shared board constants: select codes, pixel colours, cell geometry, plotter states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package othello_pkg;

    localparam int CELL       = 12;           // cell edge in pixels
    localparam int CELL_PITCH = CELL + 1;     // on-screen distance between cell origins
    localparam int DISK_R2    = 100;          // disk threshold, doubled-coordinate units

    localparam logic [1:0] SEL_EMPTY = 2'd0;
    localparam logic [1:0] SEL_BOX   = 2'd1;
    localparam logic [1:0] SEL_BLACK = 2'd2;
    localparam logic [1:0] SEL_WHITE = 2'd3;

    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_WHITE  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } plot_state_t;

endpackage

// File: rtl/cell_plotter_disk_mask.sv
// Maps a cell-relative pixel (dx,dy) to "inside the disk" using u^2+v^2 <= DISK_R2.
// Latency: purely combinational.
// Backpressure: none; kept standalone so a ROM can replace it.
module disk_mask #(
    parameter int CELL    = 12,
    parameter int DISK_R2 = 100
) (
    input  logic [3:0] i_dx,
    input  logic [3:0] i_dy,
    output logic       o_in_disk
);

    // Doubled coordinates centre the disk on the cell even when CELL is even.
    logic signed [6:0]  w_u;
    logic signed [6:0]  w_v;
    logic signed [13:0] w_u_ext;
    logic signed [13:0] w_v_ext;
    logic signed [13:0] w_u2;
    logic signed [13:0] w_v2;
    logic        [14:0] w_sum;

    assign w_u     = $signed({2'b00, i_dx, 1'b0}) - $signed(7'(CELL - 1));
    assign w_v     = $signed({2'b00, i_dy, 1'b0}) - $signed(7'(CELL - 1));
    assign w_u_ext = 14'(w_u);
    assign w_v_ext = 14'(w_v);
    assign w_u2    = w_u_ext * w_u_ext;
    assign w_v2    = w_v_ext * w_v_ext;
    assign w_sum   = {1'b0, w_u2} + {1'b0, w_v2};

    assign o_in_disk = (w_sum <= 15'(DISK_R2));

endmodule

// File: rtl/cell_plotter.sv
// Walks one cell's pixels row-major, one per clock, driving VGA x/y/colour/plot; pulses done.
// Latency: accept at T, pixels T+1..T+CELL^2, done at T+CELL^2+1 (CELL_PLOTTER_GRID_EN: (CELL+1)^2 scan).
// Backpressure: none; start is only sampled in IDLE, requests during a draw are dropped.
module cell_plotter #(
    parameter int CELL    = othello_pkg::CELL,
    parameter int DISK_R2 = othello_pkg::DISK_R2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x_origin,
    input  logic [6:0] y_origin,
    input  logic [1:0] select,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    import othello_pkg::*;

`ifdef CELL_PLOTTER_GRID_EN
    // The extra column/row at index CELL is the right/bottom grid line.
    localparam logic [3:0] SCAN_MAX = 4'(CELL);
`else
    localparam logic [3:0] SCAN_MAX = 4'(CELL - 1);
`endif
    localparam logic [3:0] EDGE_MAX = 4'(CELL - 1);

    plot_state_t r_state;
    plot_state_t w_state_n;

    logic [7:0] r_x0;
    logic [6:0] r_y0;
    logic [1:0] r_sel;
    logic [3:0] r_dx;
    logic [3:0] r_dy;
    logic [3:0] w_dx_n;
    logic [3:0] w_dy_n;
    logic       w_accept;
    logic [7:0] w_x0_n;
    logic [6:0] w_y0_n;
    logic [1:0] w_sel_n;
    logic       w_in_disk;
    logic [2:0] w_colour_n;

    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_n;
    end

    // Next state and next pixel position; counters name the pixel being driven.
    always_comb begin
        w_state_n = r_state;
        w_dx_n    = r_dx;
        w_dy_n    = r_dy;
        w_accept  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_DRAW;
                    w_accept  = 1'b1;
                    w_dx_n    = 4'd0;
                    w_dy_n    = 4'd0;
                end
            end
            ST_DRAW: begin
                if (r_dx == SCAN_MAX) begin
                    w_dx_n = 4'd0;
                    if (r_dy == SCAN_MAX) begin
                        w_state_n = ST_DONE;
                        w_dy_n    = 4'd0;
                    end else begin
                        w_dy_n = r_dy + 4'd1;
                    end
                end else begin
                    w_dx_n = r_dx + 4'd1;
                end
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    // On accept the fresh inputs feed the first pixel directly, so T+1 is already registered.
    assign w_x0_n  = w_accept ? x_origin : r_x0;
    assign w_y0_n  = w_accept ? y_origin : r_y0;
    assign w_sel_n = w_accept ? select   : r_sel;

    disk_mask #(.CELL(CELL), .DISK_R2(DISK_R2)) u_disk_mask (
        .i_dx      (w_dx_n),
        .i_dy      (w_dy_n),
        .o_in_disk (w_in_disk)
    );

    // Colour of the next pixel from the drawing code and its cell-relative position.
    always_comb begin
        w_colour_n = COL_GREEN;
        case (w_sel_n)
            SEL_BOX: begin
                if (w_dx_n == 4'd0 || w_dx_n == EDGE_MAX || w_dy_n == 4'd0 || w_dy_n == EDGE_MAX)
                    w_colour_n = COL_YELLOW;
            end
            SEL_BLACK: if (w_in_disk) w_colour_n = COL_BLACK;
            SEL_WHITE: if (w_in_disk) w_colour_n = COL_WHITE;
            default:   w_colour_n = COL_GREEN;
        endcase
`ifdef CELL_PLOTTER_GRID_EN
        if (w_dx_n == 4'(CELL) || w_dy_n == 4'(CELL))
            w_colour_n = COL_BLACK;
`endif
    end

    // Latches, counters and registered pixel outputs; x/y/colour hold while not plotting.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x0     <= 8'd0;
            r_y0     <= 7'd0;
            r_sel    <= SEL_EMPTY;
            r_dx     <= 4'd0;
            r_dy     <= 4'd0;
            r_vga_x  <= 8'd0;
            r_vga_y  <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_x0   <= w_x0_n;
            r_y0   <= w_y0_n;
            r_sel  <= w_sel_n;
            r_dx   <= w_dx_n;
            r_dy   <= w_dy_n;
            r_plot <= (w_state_n == ST_DRAW);
            r_busy <= (w_state_n != ST_IDLE);
            r_done <= (w_state_n == ST_DONE);
            if (w_state_n == ST_DRAW) begin
                r_vga_x  <= w_x0_n + {4'd0, w_dx_n};
                r_vga_y  <= w_y0_n + {3'd0, w_dy_n};
                r_colour <= w_colour_n;
            end
        end
    end

    assign vga_x  = r_vga_x;
    assign vga_y  = r_vga_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
